// File: rtl/theta_slice_source.sv
// Transmit end of the theta slice interface: holds an NSLICE x WIDTH state image and
// streams each slice together with its wrapped predecessor over a valid/ready handshake.
module theta_slice_source #(
    parameter int WIDTH  = 25,
    parameter int NSLICE = 64,
    parameter int IDX_W  = $clog2(NSLICE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] curr_slice,
    output logic [WIDTH-1:0] pre_slice,
    output logic [IDX_W-1:0] slice_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state_q;
    logic             outValid_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] currSlice_q;
    logic [WIDTH-1:0] preSlice_q;
    logic [IDX_W-1:0] sliceIdx_q;
    logic [IDX_W-1:0] sliceIdx_d;

    logic [WIDTH-1:0] mem [NSLICE];

    assign sliceIdx_d = sliceIdx_q + IDX_W'(1);

    // The image is frozen for the whole pass so a sink never sees a half-updated state.
    always_ff @(posedge clk) begin
        if (load_en && !busy_q) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            outValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            currSlice_q <= '0;
            preSlice_q  <= '0;
            sliceIdx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= PRIME;
                        busy_q     <= 1'b1;
                        sliceIdx_q <= '0;
                    end
                end
                PRIME: begin
                    currSlice_q <= mem[0];
                    preSlice_q  <= mem[NSLICE-1];
                    outValid_q  <= 1'b1;
                    state_q     <= STREAM;
                end
                STREAM: begin
                    // The predecessor is always the slice just sent, so only one read per step.
                    if (out_ready) begin
                        if (sliceIdx_q == LAST_IDX) begin
                            outValid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            preSlice_q  <= currSlice_q;
                            currSlice_q <= mem[sliceIdx_d];
                            sliceIdx_q  <= sliceIdx_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = outValid_q;
    assign curr_slice = currSlice_q;
    assign pre_slice  = preSlice_q;
    assign slice_idx  = sliceIdx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_theta_slice_source.sv
// Directed self-checking bench for theta_slice_source: reset, full passes with and
// without backpressure, loads while busy, same-cycle load+start, and ignored starts.
module tb_theta_slice_source;

    localparam int WIDTH  = 25;
    localparam int NSLICE = 64;
    localparam int IDX_W  = 6;

    logic             clk;
    logic             rst;
    logic             load_en;
    logic [IDX_W-1:0] load_addr;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] curr_slice;
    logic [WIDTH-1:0] pre_slice;
    logic [IDX_W-1:0] slice_idx;
    logic             busy;
    logic             done;

    int checks;
    int errors;
    logic [WIDTH-1:0] model [NSLICE];

    int               passEdges;
    int               passXfers;
    int               passDones;
    logic [WIDTH-1:0] firstCurr;
    logic [WIDTH-1:0] firstPre;

    theta_slice_source #(.WIDTH(WIDTH), .NSLICE(NSLICE), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .curr_slice (curr_slice),
        .pre_slice  (pre_slice),
        .slice_idx  (slice_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [IDX_W-1:0] addr, input logic [WIDTH-1:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    // mode 0: ready=1; mode 1: ready 1,0,0 repeating; mode 2: ready=1 with start held while busy;
    // mode 3: ready=1 with a write to slice 3 attempted mid-pass.
    // Entered right after the start edge, which counts as edge 1.
    task automatic runPass(input int mode);
        int               k;
        logic [WIDTH-1:0] holdCurr;
        logic [WIDTH-1:0] holdPre;
        logic [IDX_W-1:0] holdIdx;
        logic             stalled;
        passEdges = 1;
        passXfers = 0;
        passDones = 0;
        stalled   = 1'b0;
        holdCurr  = '0;
        holdPre   = '0;
        holdIdx   = '0;
        for (k = 0; k < 400; k++) begin
            if (stalled) begin
                checkOutput("stallValid", {31'd0, out_valid}, 32'd1);
                checkOutput("stallCurr", {7'd0, curr_slice}, {7'd0, holdCurr});
                checkOutput("stallPre", {7'd0, pre_slice}, {7'd0, holdPre});
                checkOutput("stallIdx", {26'd0, slice_idx}, {26'd0, holdIdx});
            end
            if (done) begin
                passDones++;
                start = (mode == 2);
                tick();
                start = 1'b0;
                break;
            end
            out_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
            start     = (mode == 2) ? busy : 1'b0;
            load_en   = (mode == 3) && (k == 10);
            load_addr = 6'd3;
            load_data = 25'h1FFFFFF;
            stalled   = out_valid && !out_ready;
            holdCurr  = curr_slice;
            holdPre   = pre_slice;
            holdIdx   = slice_idx;
            if (out_valid && out_ready) begin
                if (passXfers == 0) begin
                    firstCurr = curr_slice;
                    firstPre  = pre_slice;
                end
                checkOutput("pairIdx", {26'd0, slice_idx}, passXfers);
                checkOutput("pairCurr", {7'd0, curr_slice}, {7'd0, model[passXfers]});
                checkOutput("pairPre", {7'd0, pre_slice}, {7'd0, model[(passXfers + NSLICE - 1) % NSLICE]});
                passXfers++;
            end
            tick();
            passEdges++;
        end
        load_en   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput("passDone", passDones, 32'd1);
        checkOutput("passXfers", passXfers, NSLICE);
        checkOutput("afterDone", {31'd0, done}, 32'd0);
        checkOutput("afterBusy", {31'd0, busy}, 32'd0);
    endtask

    task automatic startPass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstCurr", {7'd0, curr_slice}, 32'd0);
        checkOutput("rstIdx", {26'd0, slice_idx}, 32'd0);

        // Scenario 1: reset in the middle of STREAM
        $display("[TB] reset mid-pass");
        for (int z = 0; z < NSLICE; z++) applyStimulus(IDX_W'(z), WIDTH'(z + 1));
        startPass();
        checkOutput("primeBusy", {31'd0, busy}, 32'd1);
        checkOutput("primeValid", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("streamValid", {31'd0, out_valid}, 32'd1);
        checkOutput("streamCurr0", {7'd0, curr_slice}, 32'd1);
        checkOutput("streamPre0", {7'd0, pre_slice}, 32'd64);
        tick();
        tick();
        checkOutput("streamIdx2", {26'd0, slice_idx}, 32'd2);
        checkOutput("streamPre2", {7'd0, pre_slice}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortValid", {31'd0, out_valid}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortCurr", {7'd0, curr_slice}, 32'd0);
        checkOutput("abortPre", {7'd0, pre_slice}, 32'd0);
        checkOutput("abortIdx", {26'd0, slice_idx}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("abortNoDone", {31'd0, done}, 32'd0);
        end

        // Scenario 2: full pass, ready held high
        $display("[TB] full pass");
        for (int z = 0; z < NSLICE; z++) begin
            model[z] = WIDTH'(z * 3 + 7);
            applyStimulus(IDX_W'(z), WIDTH'(z * 3 + 7));
        end
        startPass();
        checkOutput("z0Curr", {7'd0, curr_slice}, 32'd0);
        tick();
        checkOutput("z0CurrDirect", {7'd0, curr_slice}, 32'd7);
        checkOutput("z0PreDirect", {7'd0, pre_slice}, 32'd196);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("z5Idx", {26'd0, slice_idx}, 32'd5);
        checkOutput("z5Curr", {7'd0, curr_slice}, 32'd22);
        checkOutput("z5Pre", {7'd0, pre_slice}, 32'd19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        startPass();
        runPass(0);
        checkOutput("startToDone", passEdges, 32'd66);

        // Scenario 3: backpressure
        $display("[TB] backpressure");
        startPass();
        runPass(1);

        // Scenario 6: start during STREAM and DONE is ignored
        $display("[TB] ignored starts");
        startPass();
        runPass(2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("noRestartBusy", {31'd0, busy}, 32'd0);
            checkOutput("noExtraDone", {31'd0, done}, 32'd0);
            tick();
        end
        startPass();
        runPass(0);
        checkOutput("cleanPassEdges", passEdges, 32'd66);

        // Scenario 4: loads while busy are dropped
        $display("[TB] load while busy");
        startPass();
        runPass(3);
        startPass();
        runPass(0);
        applyStimulus(6'd3, 25'h1FFFFFF);
        model[3] = 25'h1FFFFFF;
        startPass();
        runPass(0);

        // Scenario 5: load and start in the same cycle
        $display("[TB] same-cycle load and start");
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = 25'h0AAAAAA;
        start     = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        model[0] = 25'h0AAAAAA;
        runPass(0);
        checkOutput("sameCycleCurr", {7'd0, firstCurr}, 32'h0AAAAAA);
        checkOutput("sameCyclePre", {7'd0, firstPre}, 32'd196);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
